// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle control unit for the 16-bit processor. Owns the program counter
// and instruction register, fetches over a req/ack handshake (so instruction
// memory may insert wait states), and sequences each instruction through a
// five-state FSM: FETCH, DECODE, EXEC, MEM, WB. Branch and jump targets are
// resolved here.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high
//   stall        freezes FSM, PC and IR; suppresses retire
//   imem_req     fetch request, high exactly in FETCH
//   imem_addr    fetch address (equals pc)
//   imem_ack     fetch accepted, imem_rdata valid in the same cycle
//   imem_rdata   fetched instruction
//   dmem_ack     data memory access complete
//   take_branch  branch condition from the ALU, sampled in EXEC
//   pc_target    absolute branch/jump target, sampled in EXEC
//   pc           program counter
//   instr        instruction register
//   regdest, alusrc, memtoreg, branch, jump   decode controls
//   memread, memwrite                          data memory strobes
//   regwrite     register-file write strobe
//   state        FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
//   retire       one-cycle pulse in the final cycle of each instruction
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               dmem_ack,
  input  logic               take_branch,
  input  logic [PC_W-1:0]    pc_target,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               regdest,
  output logic               alusrc,
  output logic               memtoreg,
  output logic               branch,
  output logic               jump,
  output logic               memread,
  output logic               memwrite,
  output logic               regwrite,
  output logic [2:0]         state,
  output logic               retire
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PC_W-1:0]      r_pc;
  logic [PC_W-1:0]      w_pc_nxt;
  logic [INSTR_W-1:0]   r_ir;
  logic [INSTR_W-1:0]   w_ir_nxt;

  logic [3:0]           w_op;
  logic                 w_is_r;
  logic                 w_is_imm;
  logic                 w_is_lw;
  logic                 w_is_sw;
  logic                 w_is_jmp;
  logic                 w_is_br;
  logic                 w_dec_en;

  // Opcode class decode from the instruction register. Every opcode maps to
  // exactly one class, so no illegal-instruction path is needed.
  always_comb begin
    w_op     = r_ir[3:0];
    w_is_r   = 1'b0;
    w_is_imm = 1'b0;
    w_is_lw  = 1'b0;
    w_is_sw  = 1'b0;
    w_is_jmp = 1'b0;
    w_is_br  = 1'b0;
    case (w_op)
      4'd5, 4'd6:   w_is_imm = 1'b1;
      4'd7:         w_is_lw  = 1'b1;
      4'd8:         w_is_sw  = 1'b1;
      4'd9:         w_is_jmp = 1'b1;
      4'd10, 4'd11: w_is_br  = 1'b1;
      default:      w_is_r   = 1'b1;
    endcase
  end

  // State, PC and IR registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  // Next-state, PC and IR update; stall freezes everything and masks acks
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    if (!stall) begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            w_state_nxt = S_DECODE;
            w_ir_nxt    = imem_rdata;
            w_pc_nxt    = r_pc + 1'b1;  // wraps modulo 2^PC_W
          end
        end
        S_DECODE: w_state_nxt = S_EXEC;
        S_EXEC: begin
          if (w_is_lw || w_is_sw) begin
            w_state_nxt = S_MEM;
          end else if (w_is_jmp) begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = pc_target;
          end else if (w_is_br) begin
            w_state_nxt = S_FETCH;
            if (take_branch) w_pc_nxt = pc_target;
          end else begin
            w_state_nxt = S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) w_state_nxt = w_is_lw ? S_WB : S_FETCH;
        end
        S_WB:    w_state_nxt = S_FETCH;
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  // Control outputs are pure functions of state and IR, so they hold by
  // themselves while stalled; only retire needs explicit masking.
  always_comb begin
    w_dec_en  = (r_state != S_FETCH);
    regdest   = w_dec_en & (w_is_r | w_is_imm);
    alusrc    = w_dec_en & (w_is_imm | w_is_lw | w_is_sw);
    memtoreg  = w_dec_en & w_is_lw;
    branch    = w_dec_en & w_is_br;
    jump      = w_dec_en & w_is_jmp;
    memread   = (r_state == S_MEM) & w_is_lw;
    memwrite  = (r_state == S_MEM) & w_is_sw;
    regwrite  = (r_state == S_WB);
    imem_req  = (r_state == S_FETCH);
    retire    = ~stall & ((r_state == S_WB) |
                          ((r_state == S_MEM) & w_is_sw & dmem_ack) |
                          ((r_state == S_EXEC) & (w_is_jmp | w_is_br)));
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_ir;
  assign state     = r_state;

endmodule
